// File: rtl/usb_trsac_ctrl.sv
// USB device transaction controller: sequences token/data/handshake for SETUP, OUT and IN,
// picks the response PID, tracks per-endpoint data toggles and reports each transaction end.
module usb_trsac_ctrl #(
  parameter logic [9:0] TIMEOUT_CYC = 10'd80
) (
  input  logic        clk,
  input  logic        rst0_async,
  input  logic        rst0_sync,
  input  logic        usb_rst,
  input  logic        usb_interpack,
  input  logic [3:0]  rdec_epaddr,
  input  logic        rdec_pidsetup,
  input  logic        rdec_pidout,
  input  logic        rdec_pidin,
  input  logic        rdec_piddata0,
  input  logic        rdec_piddata1,
  input  logic        rdec_pidack,
  input  logic [15:0] ep_stall,
  input  logic [15:0] ep_rdy_out,
  input  logic [15:0] ep_rdy_in,
  output logic        enc_req,
  output logic [3:0]  enc_pid,
  input  logic        enc_ack,
  output logic        trsac_done,
  output logic        trsac_ok,
  output logic [1:0]  trsac_type,
  output logic [3:0]  trsac_ep,
  output logic [15:0] ep_toggle
);

  localparam logic [3:0] PID_ACK = 4'b0010, PID_NAK = 4'b1010, PID_STALL = 4'b1110;
  localparam logic [3:0] PID_D0 = 4'b0011, PID_D1 = 4'b1011;
  localparam logic [1:0] T_SETUP = 2'd0, T_OUT = 2'd1, T_IN = 2'd2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_DATA, S_WAIT_GAP, S_SEND, S_WAIT_ACK} state_t;

  state_t      r_state, w_nx;
  logic [9:0]  r_cnt;
  logic [3:0]  r_ep, r_pid, r_dep;
  logic [1:0]  r_type, r_dtype;
  logic        r_req, r_done, r_ok, r_okp, r_twe_p, r_tval_p, r_isdata;
  logic [15:0] r_tgl;

  logic       w_tok, w_tmo, w_cur, w_srst;
  logic       w_done, w_ok, w_latch, w_pid_ld, w_okp, w_twe_p, w_tval_p, w_isdata;
  logic       w_tgl_we, w_tgl_val;
  logic [3:0] w_pid;
  logic [1:0] w_tok_type;

  assign w_tok  = rdec_pidsetup | rdec_pidout | rdec_pidin;
  assign w_tmo  = (r_cnt == TIMEOUT_CYC - 10'd1);
  assign w_cur  = r_tgl[r_ep];
  assign w_srst = !rst0_sync || usb_rst;
  assign w_tok_type = rdec_pidin ? T_IN : (rdec_pidout ? T_OUT : T_SETUP);

  always_comb begin
    w_nx = r_state;
    w_done = 1'b0; w_ok = 1'b0; w_latch = 1'b0;
    w_pid_ld = 1'b0; w_pid = PID_ACK; w_okp = 1'b0; w_twe_p = 1'b0; w_tval_p = 1'b0;
    w_isdata = 1'b0; w_tgl_we = 1'b0; w_tgl_val = 1'b0;
    case (r_state)
      S_IDLE: if (w_tok) begin
        w_latch = 1'b1;
        w_nx = rdec_pidin ? S_WAIT_GAP : S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (w_tok) begin
          // abandoned transaction is reported while the new token is taken as from IDLE
          w_done = 1'b1; w_latch = 1'b1;
          w_nx = rdec_pidin ? S_WAIT_GAP : S_WAIT_DATA;
        end else if (w_tmo) begin
          w_done = 1'b1; w_nx = S_IDLE;
        end else if (rdec_piddata0 || rdec_piddata1) begin
          w_nx = S_WAIT_GAP; w_pid_ld = 1'b1;
          if (r_type == T_SETUP) begin
            w_okp = 1'b1; w_twe_p = 1'b1; w_tval_p = 1'b1;
          end else if (ep_stall[r_ep]) w_pid = PID_STALL;
          else if (!ep_rdy_out[r_ep]) w_pid = PID_NAK;
          else if (rdec_piddata1 == w_cur) begin
            w_okp = 1'b1; w_twe_p = 1'b1; w_tval_p = !w_cur;
          end
        end
      end
      S_WAIT_GAP: if (usb_interpack) begin
        w_nx = S_SEND;
        if (r_type == T_IN) begin
          w_pid_ld = 1'b1;
          if (ep_stall[r_ep]) w_pid = PID_STALL;
          else if (!ep_rdy_in[r_ep]) w_pid = PID_NAK;
          else begin
            w_isdata = 1'b1; w_pid = w_cur ? PID_D1 : PID_D0;
          end
        end
      end
      S_SEND: if (enc_ack) begin
        if (r_isdata) w_nx = S_WAIT_ACK;
        else begin
          // handshake is on the wire: commit the deferred toggle with the done pulse
          w_done = 1'b1; w_ok = r_okp; w_tgl_we = r_twe_p; w_tgl_val = r_tval_p;
          w_nx = S_IDLE;
        end
      end
      S_WAIT_ACK: begin
        if (rdec_pidack) begin
          w_done = 1'b1; w_ok = 1'b1; w_tgl_we = 1'b1; w_tgl_val = !w_cur; w_nx = S_IDLE;
        end else if (w_tok || w_tmo) begin
          w_done = 1'b1; w_nx = S_IDLE;
        end
      end
      default: w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst0_async) begin
    if (!rst0_async) begin
      r_state <= S_IDLE; r_cnt <= '0; r_ep <= '0; r_type <= '0; r_pid <= '0;
      r_req <= 1'b0; r_done <= 1'b0; r_ok <= 1'b0; r_dtype <= '0; r_dep <= '0;
      r_okp <= 1'b0; r_twe_p <= 1'b0; r_tval_p <= 1'b0; r_isdata <= 1'b0; r_tgl <= '0;
    end else if (w_srst) begin
      r_state <= S_IDLE; r_cnt <= '0; r_ep <= '0; r_type <= '0; r_pid <= '0;
      r_req <= 1'b0; r_done <= 1'b0; r_ok <= 1'b0; r_dtype <= '0; r_dep <= '0;
      r_okp <= 1'b0; r_twe_p <= 1'b0; r_tval_p <= 1'b0; r_isdata <= 1'b0; r_tgl <= '0;
    end else begin
      r_state <= w_nx;
      if (w_nx != r_state || w_latch) r_cnt <= '0;
      else if (r_state == S_WAIT_DATA || r_state == S_WAIT_ACK) r_cnt <= r_cnt + 10'd1;
      else r_cnt <= '0;
      r_req  <= (w_nx == S_SEND);
      r_done <= w_done;
      if (w_done) begin
        r_ok <= w_ok; r_dtype <= r_type; r_dep <= r_ep;
      end
      if (w_latch) begin
        r_ep <= rdec_epaddr; r_type <= w_tok_type;
      end
      if (w_pid_ld) begin
        r_pid <= w_pid; r_okp <= w_okp; r_twe_p <= w_twe_p;
        r_tval_p <= w_tval_p; r_isdata <= w_isdata;
      end
      if (w_tgl_we) r_tgl[r_ep] <= w_tgl_val;
    end
  end

  assign enc_req    = r_req;
  assign enc_pid    = r_pid;
  assign trsac_done = r_done;
  assign trsac_ok   = r_ok;
  assign trsac_type = r_dtype;
  assign trsac_ep   = r_dep;
  assign ep_toggle  = r_tgl;

endmodule

// File: tb/tb_usb_trsac_ctrl.sv
// Bench for usb_trsac_ctrl: directed vector table, hand-built corner sequences, then
// random transactions scored against a transaction-level toggle/response model.
module tb_usb_trsac_ctrl;
  logic        clk = 1'b0, rst0_async = 1'b0, rst0_sync = 1'b1, usb_rst = 1'b0;
  logic        usb_interpack = 1'b0;
  logic [3:0]  rdec_epaddr = '0;
  logic        rdec_pidsetup = 0, rdec_pidout = 0, rdec_pidin = 0;
  logic        rdec_piddata0 = 0, rdec_piddata1 = 0, rdec_pidack = 0;
  logic [15:0] ep_stall = '0, ep_rdy_out = '0, ep_rdy_in = '0;
  logic        enc_req, enc_ack = 1'b0, trsac_done, trsac_ok;
  logic [3:0]  enc_pid, trsac_ep;
  logic [1:0]  trsac_type;
  logic [15:0] ep_toggle;

  int total = 0, bad = 0;

  usb_trsac_ctrl #(.TIMEOUT_CYC(10'd80)) dut (
    .clk(clk), .rst0_async(rst0_async), .rst0_sync(rst0_sync), .usb_rst(usb_rst),
    .usb_interpack(usb_interpack), .rdec_epaddr(rdec_epaddr),
    .rdec_pidsetup(rdec_pidsetup), .rdec_pidout(rdec_pidout), .rdec_pidin(rdec_pidin),
    .rdec_piddata0(rdec_piddata0), .rdec_piddata1(rdec_piddata1), .rdec_pidack(rdec_pidack),
    .ep_stall(ep_stall), .ep_rdy_out(ep_rdy_out), .ep_rdy_in(ep_rdy_in),
    .enc_req(enc_req), .enc_pid(enc_pid), .enc_ack(enc_ack),
    .trsac_done(trsac_done), .trsac_ok(trsac_ok), .trsac_type(trsac_type),
    .trsac_ep(trsac_ep), .ep_toggle(ep_toggle));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] typ; logic [3:0] ep; logic dpid, stall, rdy, ack;
    logic [3:0] epid; logic eok, etgl;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic pulse_tok(input logic [1:0] typ, input logic [3:0] ep);
    usb_interpack = 1'b0;
    rdec_epaddr = ep;
    rdec_pidsetup = (typ == 2'd0); rdec_pidout = (typ == 2'd1); rdec_pidin = (typ == 2'd2);
    @(negedge clk);
    rdec_pidsetup = 0; rdec_pidout = 0; rdec_pidin = 0;
  endtask

  task automatic send_data(input logic d);
    repeat (2) @(negedge clk);
    if (d) rdec_piddata1 = 1'b1; else rdec_piddata0 = 1'b1;
    @(negedge clk);
    rdec_piddata0 = 0; rdec_piddata1 = 0;
  endtask

  task automatic finish(input logic ack, input int gap, output logic [3:0] pid,
                        output logic got, output logic ok, output logic [1:0] ty,
                        output logic [3:0] ep, output int cyc);
    int n;
    got = 0; pid = '0; ok = 0; ty = '0; ep = '0; cyc = 0; n = 0;
    usb_interpack = 1'b0;
    repeat (gap) @(negedge clk);
    usb_interpack = 1'b1;
    while (!enc_req && n < 50) begin @(negedge clk); n++; end
    if (!enc_req) return;
    pid = enc_pid;
    repeat (2) @(negedge clk);
    enc_ack = 1'b1; @(negedge clk); enc_ack = 1'b0;
    if ((pid == 4'b0011 || pid == 4'b1011) && ack) begin
      repeat (3) @(negedge clk);
      rdec_pidack = 1'b1; @(negedge clk); rdec_pidack = 1'b0;
    end
    while (!trsac_done && cyc < 300) begin @(negedge clk); cyc++; end
    if (trsac_done) begin
      got = 1; ok = trsac_ok; ty = trsac_type; ep = trsac_ep;
    end
  endtask

  // full transaction with expected handshake/report checks; toggle checked by caller
  task automatic do_vec(input string nm, input logic [1:0] typ, input logic [3:0] ep,
                        input logic dpid, input logic ack, input int gap,
                        input logic [3:0] epid, input logic eok);
    logic [3:0] pid, rep; logic got, ok; logic [1:0] ty; int cyc;
    pulse_tok(typ, ep);
    if (typ != 2'd2) send_data(dpid);
    finish(ack, gap, pid, got, ok, ty, rep, cyc);
    chk({nm, ".done"}, 16'(got), 16'd1);
    chk({nm, ".pid"}, 16'(pid), 16'(epid));
    chk({nm, ".ok"}, 16'(ok), 16'(eok));
    chk({nm, ".type"}, 16'(ty), 16'(typ));
    chk({nm, ".ep"}, 16'(rep), 16'(ep));
    @(negedge clk);
    chk({nm, ".pulse1"}, 16'(trsac_done), 16'd0);
  endtask

  initial begin
    logic [3:0] pid, rep; logic got, ok; logic [1:0] ty; int cyc, n, seen;
    logic [15:0] m_tgl;
    tbl[0]  = '{2'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
    tbl[1]  = '{2'd1, 4'd2, 1'b1, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0};
    tbl[2]  = '{2'd1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
    tbl[3]  = '{2'd0, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b0010, 1'b1, 1'b1};
    tbl[4]  = '{2'd2, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'b1011, 1'b0, 1'b1};
    tbl[5]  = '{2'd2, 4'd1, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0};
    tbl[6]  = '{2'd2, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0};
    tbl[7]  = '{2'd2, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0};
    tbl[8]  = '{2'd1, 4'd4, 1'b0, 1'b1, 1'b1, 1'b0, 4'b1110, 1'b0, 1'b0};
    tbl[9]  = '{2'd1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 1'b0};
    tbl[10] = '{2'd2, 4'd2, 1'b0, 1'b0, 1'b1, 1'b1, 4'b1011, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst0_async = 1'b1;
    @(negedge clk);
    chk("rst.req", 16'(enc_req), 16'd0);
    chk("rst.pid", 16'(enc_pid), 16'd0);
    chk("rst.done", 16'(trsac_done), 16'd0);
    chk("rst.ok", 16'(trsac_ok), 16'd0);
    chk("rst.type", 16'(trsac_type), 16'd0);
    chk("rst.ep", 16'(trsac_ep), 16'd0);
    chk("rst.tgl", ep_toggle, 16'h0000);

    // late ACK/data strobes in IDLE must not start anything
    rdec_pidack = 1'b1; rdec_piddata0 = 1'b1; @(negedge clk);
    rdec_pidack = 1'b0; rdec_piddata0 = 1'b0; @(negedge clk);
    chk("idle.ignore_req", 16'(enc_req), 16'd0);
    chk("idle.ignore_done", 16'(trsac_done), 16'd0);

    foreach (tbl[i]) begin
      ep_stall   = tbl[i].stall ? (16'h1 << tbl[i].ep) : 16'h0;
      ep_rdy_out = tbl[i].rdy ? (16'h1 << tbl[i].ep) : 16'h0;
      ep_rdy_in  = ep_rdy_out;
      do_vec($sformatf("vec%0d", i), tbl[i].typ, tbl[i].ep, tbl[i].dpid, tbl[i].ack, 1,
             tbl[i].epid, tbl[i].eok);
      chk($sformatf("vec%0d.tgl", i), 16'(ep_toggle[tbl[i].ep]), 16'(tbl[i].etgl));
    end
    // toggles now: ep0=1, ep1=0, ep2=0
    chk("vec.tgl_all", ep_toggle, 16'h0001);

    // WAIT_DATA timeout: exactly TIMEOUT_CYC cycles after the token edge
    pulse_tok(2'd1, 4'd5);
    cyc = 0;
    while (!trsac_done && cyc < 300) begin @(negedge clk); cyc++; end
    chk("tmo.cycles", 16'(cyc), 16'd80);
    chk("tmo.ok", 16'(trsac_ok), 16'd0);
    chk("tmo.type", 16'(trsac_type), 16'd1);
    chk("tmo.ep", 16'(trsac_ep), 16'd5);
    @(negedge clk);

    // OUT ep0 abandoned by SETUP ep0; SETUP then completes normally
    ep_stall = '0; ep_rdy_out = '0;
    pulse_tok(2'd1, 4'd0);
    @(negedge clk);
    pulse_tok(2'd0, 4'd0);
    chk("abort.done", 16'(trsac_done), 16'd1);
    chk("abort.ok", 16'(trsac_ok), 16'd0);
    chk("abort.type", 16'(trsac_type), 16'd1);
    send_data(1'b0);
    finish(1'b0, 0, pid, got, ok, ty, rep, cyc);
    chk("abort.setup_done", 16'(got), 16'd1);
    chk("abort.setup_pid", 16'(pid), 16'h2);
    chk("abort.setup_ok", 16'(ok), 16'd1);
    chk("abort.setup_type", 16'(ty), 16'd0);
    chk("abort.tgl", ep_toggle, 16'h0001);
    @(negedge clk);

    // WAIT_ACK abort by a new token: ok=0 and toggle kept
    ep_rdy_in = 16'h0001;
    pulse_tok(2'd2, 4'd0);
    usb_interpack = 1'b1; n = 0;
    while (!enc_req && n < 50) begin @(negedge clk); n++; end
    chk("wack.pid", 16'(enc_pid), 16'hB);
    enc_ack = 1'b1; @(negedge clk); enc_ack = 1'b0;
    repeat (2) @(negedge clk);
    pulse_tok(2'd1, 4'd7);
    chk("wack.done", 16'(trsac_done), 16'd1);
    chk("wack.ok", 16'(trsac_ok), 16'd0);
    chk("wack.tgl", ep_toggle, 16'h0001);
    repeat (3) @(negedge clk);
    chk("wack.idle_req", 16'(enc_req), 16'd0);

    // bus reset mid-SEND
    ep_rdy_in = 16'h0040;
    pulse_tok(2'd2, 4'd6);
    usb_interpack = 1'b1; n = 0;
    while (!enc_req && n < 50) begin @(negedge clk); n++; end
    chk("busrst.req_before", 16'(enc_req), 16'd1);
    usb_rst = 1'b1; @(negedge clk); usb_rst = 1'b0;
    chk("busrst.req", 16'(enc_req), 16'd0);
    chk("busrst.tgl", ep_toggle, 16'h0000);
    chk("busrst.pid", 16'(enc_pid), 16'd0);
    enc_ack = 1'b1; @(negedge clk); enc_ack = 1'b0;
    seen = 0;
    repeat (6) begin @(negedge clk); if (trsac_done || enc_req) seen++; end
    chk("busrst.quiet", 16'(seen), 16'd0);

    // synchronous reset clears toggles set by a SETUP
    ep_stall = '0;
    do_vec("srst_setup", 2'd0, 4'd9, 1'b0, 1'b0, 0, 4'h2, 1'b1);
    chk("srst.tgl_set", ep_toggle, 16'h0200);
    rst0_sync = 1'b0; @(negedge clk); rst0_sync = 1'b1;
    chk("srst.tgl", ep_toggle, 16'h0000);

    // random transactions vs transaction-level model
    m_tgl = '0;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] typ; logic [3:0] ep, epid; logic dpid, ack, eok, st, ro, ri;
      typ = 2'($urandom_range(0, 2));
      ep = 4'($urandom_range(0, 15));
      dpid = 1'($urandom_range(0, 1));
      ack = 1'($urandom_range(0, 1));
      ep_stall = 16'($urandom & $urandom & $urandom);
      ep_rdy_out = 16'($urandom | $urandom);
      ep_rdy_in = 16'($urandom | $urandom);
      st = ep_stall[ep]; ro = ep_rdy_out[ep]; ri = ep_rdy_in[ep];
      eok = 1'b0; epid = 4'h2;
      if (typ == 2'd0) begin
        eok = 1'b1; m_tgl[ep] = 1'b1;
      end else if (typ == 2'd1) begin
        if (st) epid = 4'hE;
        else if (!ro) epid = 4'hA;
        else if (dpid == m_tgl[ep]) begin eok = 1'b1; m_tgl[ep] = !m_tgl[ep]; end
      end else begin
        if (st) epid = 4'hE;
        else if (!ri) epid = 4'hA;
        else begin
          epid = m_tgl[ep] ? 4'hB : 4'h3;
          if (ack) begin eok = 1'b1; m_tgl[ep] = !m_tgl[ep]; end
        end
      end
      do_vec($sformatf("rnd%0d", k), typ, ep, dpid, ack, int'($urandom_range(0, 3)), epid, eok);
      chk($sformatf("rnd%0d.tgl", k), ep_toggle, m_tgl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
